tpu_cfg_writer: RTL

//  Host-side initiator for the TPU register-write port (addr / data / valid).

---
 rtl/tpu_cfg_writer_if.sv | 17 +
 rtl/tpu_cfg_writer.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tpu_cfg_writer_if.sv
`default_nettype none
// ============================================================================
// Module      : tpu_cfg_writer_if
// Description : TPU register-write bus (addr / data / valid strobe).
//               The master drives single-cycle writes; the slave (TPU) only
//               observes them, there is no backpressure.
// Revision    : 1.0 - initial release
// ============================================================================
interface tpu_cfg_writer_if;
  logic [7:0] addr;
  logic [7:0] data_out;
  logic       valid;

  modport master (output addr, output data_out, output valid);
  modport slave  (input  addr, input  data_out, input  valid);
endinterface
`default_nettype wire

// File: rtl/tpu_cfg_writer.sv
`default_nettype none
// ============================================================================
// Module      : tpu_cfg_writer
// Description : Latches a full TPU configuration on start and replays it as a
//               fixed sequence of single-cycle register writes:
//               TX_SLOT, RX_SLOT, TIMER_LO, TIMER_HI, CTRL (CTRL last so the
//               TPU enables see a consistent configuration). Each write is
//               followed by GAP_CYCLES idle cycles.
//               Optional feature macro: TPU_CFG_MASK_EN adds cfg_mask[4:0]
//               ([0]=CTRL [1]=TX [2]=RX [3]=TLO [4]=THI) to skip writes.
// Revision    : 1.0 - initial release
// ============================================================================
module tpu_cfg_writer #(
  parameter logic [7:0] BASE_ADDR  = 8'h20,
  parameter int         GAP_CYCLES = 2
) (
  input  wire logic        SYS_CLK,
  input  wire logic        RST,
  input  wire logic        start,
  input  wire logic [7:0]  cfg_ctrl,
  input  wire logic [7:0]  cfg_tx_slot,
  input  wire logic [7:0]  cfg_rx_slot,
  input  wire logic [15:0] cfg_timer,
`ifdef TPU_CFG_MASK_EN
  input  wire logic [4:0]  cfg_mask,
`endif
  tpu_cfg_writer_if.master tpu,
  output logic             busy,
  output logic             done
);

  // Gap length as a counter-width constant (legal range 0..15).
  localparam logic [3:0] c_gap = 4'(GAP_CYCLES);

  // Write slots are held in replay order: 0=TX 1=RX 2=TLO 3=THI 4=CTRL.
  localparam logic [2:0] c_slot_tx  = 3'd0;
  localparam logic [2:0] c_slot_rx  = 3'd1;
  localparam logic [2:0] c_slot_tlo = 3'd2;
  localparam logic [2:0] c_slot_thi = 3'd3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_GAP   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic [4:0]  r_pend;        // writes still outstanding, replay order
  logic [3:0]  r_gap_cnt;
  logic [7:0]  r_ctrl;
  logic [7:0]  r_tx;
  logic [7:0]  r_rx;
  logic [15:0] r_timer;

  logic [7:0]  r_addr;
  logic [7:0]  r_data;
  logic        r_valid;
  logic        r_busy;
  logic        r_done;

  logic [4:0]  w_start_pend;
  logic [4:0]  w_src_pend;
  logic [7:0]  w_src_ctrl;
  logic [7:0]  w_src_tx;
  logic [7:0]  w_src_rx;
  logic [15:0] w_src_timer;
  logic [2:0]  w_sel;
  logic [4:0]  w_sel_oh;
  logic        w_have;
  logic [7:0]  w_wr_addr;
  logic [7:0]  w_wr_data;
  logic        w_issue;
  logic        w_accept;
  logic [3:0]  w_gap_nxt;

`ifdef TPU_CFG_MASK_EN
  // Reorder the host mask from register order into replay order.
  assign w_start_pend = {cfg_mask[0], cfg_mask[4:1]};
`else
  assign w_start_pend = 5'b11111;
`endif

  // In IDLE the first write is issued on the same edge that latches the
  // configuration, so the live inputs stand in for the latched copies.
  assign w_accept    = (r_state == S_IDLE) && start;
  assign w_src_pend  = (r_state == S_IDLE) ? w_start_pend : r_pend;
  assign w_src_ctrl  = (r_state == S_IDLE) ? cfg_ctrl     : r_ctrl;
  assign w_src_tx    = (r_state == S_IDLE) ? cfg_tx_slot  : r_tx;
  assign w_src_rx    = (r_state == S_IDLE) ? cfg_rx_slot  : r_rx;
  assign w_src_timer = (r_state == S_IDLE) ? cfg_timer    : r_timer;
  assign w_have      = |w_src_pend;
  assign w_sel_oh    = 5'b00001 << w_sel;

  // Pick the earliest outstanding write in replay order.
  always_comb begin
    w_sel = 3'd0;
    for (int i = 4; i >= 0; i--) begin
      if (w_src_pend[i]) begin
        w_sel = 3'(i);
      end
    end
  end

  // Address and data for the selected write slot.
  always_comb begin
    w_wr_addr = BASE_ADDR;
    w_wr_data = w_src_ctrl;
    case (w_sel)
      c_slot_tx: begin
        w_wr_addr = BASE_ADDR + 8'd1;
        w_wr_data = w_src_tx;
      end
      c_slot_rx: begin
        w_wr_addr = BASE_ADDR + 8'd2;
        w_wr_data = w_src_rx;
      end
      c_slot_tlo: begin
        w_wr_addr = BASE_ADDR + 8'd3;
        w_wr_data = w_src_timer[7:0];
      end
      c_slot_thi: begin
        w_wr_addr = BASE_ADDR + 8'd4;
        w_wr_data = w_src_timer[15:8];
      end
      default: begin
        w_wr_addr = BASE_ADDR;
        w_wr_data = w_src_ctrl;
      end
    endcase
  end

  // Next-state logic; w_issue marks the edge on which a write pulse starts.
  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    w_gap_nxt   = r_gap_cnt;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (w_have) begin
            w_issue     = 1'b1;
            w_state_nxt = S_WRITE;
          end else begin
            w_state_nxt = S_DONE;
          end
        end
      end
      S_WRITE: begin
        if (c_gap != 4'd0) begin
          w_state_nxt = S_GAP;
          w_gap_nxt   = c_gap - 4'd1;
        end else if (w_have) begin
          w_issue     = 1'b1;
          w_state_nxt = S_WRITE;
        end else begin
          w_state_nxt = S_DONE;
        end
      end
      S_GAP: begin
        if (r_gap_cnt == 4'd0) begin
          if (w_have) begin
            w_issue     = 1'b1;
            w_state_nxt = S_WRITE;
          end else begin
            w_state_nxt = S_DONE;
          end
        end else begin
          w_gap_nxt = r_gap_cnt - 4'd1;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge SYS_CLK or posedge RST) begin
    if (RST) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Configuration latch, outstanding-write bookkeeping and gap counter.
  always_ff @(posedge SYS_CLK or posedge RST) begin
    if (RST) begin
      r_ctrl    <= 8'd0;
      r_tx      <= 8'd0;
      r_rx      <= 8'd0;
      r_timer   <= 16'd0;
      r_pend    <= 5'd0;
      r_gap_cnt <= 4'd0;
    end else begin
      if (w_accept) begin
        r_ctrl  <= cfg_ctrl;
        r_tx    <= cfg_tx_slot;
        r_rx    <= cfg_rx_slot;
        r_timer <= cfg_timer;
      end
      if (w_issue) begin
        r_pend <= w_src_pend & ~w_sel_oh;
      end else if (w_accept) begin
        r_pend <= w_src_pend;
      end
      r_gap_cnt <= w_gap_nxt;
    end
  end

  // Registered bus and status outputs; addr/data move only with a new pulse.
  always_ff @(posedge SYS_CLK or posedge RST) begin
    if (RST) begin
      r_addr  <= 8'd0;
      r_data  <= 8'd0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_valid <= w_issue;
      if (w_issue) begin
        r_addr <= w_wr_addr;
        r_data <= w_wr_data;
      end
      r_busy <= (w_state_nxt == S_WRITE) || (w_state_nxt == S_GAP);
      r_done <= (w_state_nxt == S_DONE);
    end
  end

  assign tpu.addr     = r_addr;
  assign tpu.data_out = r_data;
  assign tpu.valid    = r_valid;
  assign busy         = r_busy;
  assign done         = r_done;

endmodule
`default_nettype wire
